// File: rtl/cp0_regfile.sv
// CP0 system-control register file: Status, Cause, EPC, BadVAddr, PRId, plus Count/Compare timer.
// Optional timer (Count/Compare and Cause.TI) is enabled by defining CP0_TIMER_INT_EN.
module cp0_regfile #(
    parameter logic [31:0] PRID       = 32'h0001_8003,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    logic [31:0] status_reg, status_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic        cause_bd_reg, cause_bd_next;
    logic [5:0]  cause_ip_hw_reg;
    logic [1:0]  cause_ip_sw_reg, cause_ip_sw_next;
    logic [4:0]  exc_code_reg, exc_code_next;
    logic        cause_ti;
    logic [31:0] count_val;
    logic [31:0] compare_val;

    logic exc_taken;
    logic exc_is_eret;
    logic exc_addr_err;
    logic mtc0_ok;

    // A committed exception of any nonzero code squashes the mtc0 of the same cycle.
    always_comb begin
        exc_taken    = 1'b0;
        exc_is_eret  = (except_type_i == 32'h0000_000e);
        exc_addr_err = (except_type_i == 32'h0000_0004) || (except_type_i == 32'h0000_0005);
        case (except_type_i)
            32'h01, 32'h04, 32'h05, 32'h08, 32'h09, 32'h0a, 32'h0c: exc_taken = 1'b1;
            default: exc_taken = 1'b0;
        endcase
        mtc0_ok = we_i && (except_type_i == 32'h0);
    end

    always_comb begin
        status_next      = status_reg;
        epc_next         = epc_reg;
        badvaddr_next    = badvaddr_reg;
        cause_bd_next    = cause_bd_reg;
        cause_ip_sw_next = cause_ip_sw_reg;
        exc_code_next    = exc_code_reg;
        if (exc_taken) begin
            // Nested exceptions keep the original return address and BD flag.
            if (!status_reg[1]) begin
                epc_next      = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
                cause_bd_next = in_delayslot_i;
            end
            status_next[1] = 1'b1;
            exc_code_next  = (except_type_i == 32'h01) ? 5'd0 : except_type_i[4:0];
            if (exc_addr_err) begin
                badvaddr_next = bad_addr_i;
            end
        end else if (exc_is_eret) begin
            status_next[1] = 1'b0;
        end else if (mtc0_ok) begin
            case (waddr_i)
                5'd12: status_next = (STATUS_RST & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
                5'd13: cause_ip_sw_next = data_i[9:8];
                5'd14: epc_next = data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg      <= STATUS_RST;
            epc_reg         <= 32'h0;
            badvaddr_reg    <= 32'h0;
            cause_bd_reg    <= 1'b0;
            cause_ip_hw_reg <= 6'h0;
            cause_ip_sw_reg <= 2'h0;
            exc_code_reg    <= 5'h0;
        end else begin
            status_reg      <= status_next;
            epc_reg         <= epc_next;
            badvaddr_reg    <= badvaddr_next;
            cause_bd_reg    <= cause_bd_next;
            cause_ip_hw_reg <= int_i;
            cause_ip_sw_reg <= cause_ip_sw_next;
            exc_code_reg    <= exc_code_next;
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        phase_reg;
    logic        timer_reg;
    logic        wr_count;
    logic        wr_compare;

    assign wr_count   = mtc0_ok && (waddr_i == 5'd9);
    assign wr_compare = mtc0_ok && (waddr_i == 5'd11);

    // Count ticks at half the clock rate; a Count write overrides the tick but not the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= 32'h0;
            compare_reg <= 32'h0;
            phase_reg   <= 1'b0;
            timer_reg   <= 1'b0;
        end else begin
            phase_reg <= ~phase_reg;
            if (wr_count) begin
                count_reg <= data_i;
            end else if (phase_reg) begin
                count_reg <= count_reg + 32'd1;
            end
            if (wr_compare) begin
                compare_reg <= data_i;
                timer_reg   <= 1'b0;
            end else if ((count_reg == compare_reg) && (compare_reg != 32'h0)) begin
                timer_reg <= 1'b1;
            end
        end
    end

    assign count_val   = count_reg;
    assign compare_val = compare_reg;
    assign cause_ti    = timer_reg;
`else
    assign count_val   = 32'h0;
    assign compare_val = 32'h0;
    assign cause_ti    = 1'b0;
`endif

    assign status_o    = status_reg;
    assign cause_o     = {cause_bd_reg, cause_ti, 14'h0, cause_ip_hw_reg, cause_ip_sw_reg,
                          1'b0, exc_code_reg, 2'b00};
    assign epc_o       = epc_reg;
    assign badvaddr_o  = badvaddr_reg;
    assign count_o     = count_val;
    assign compare_o   = compare_val;
    assign timer_int_o = cause_ti;

    logic [31:0] reg_view [0:31];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_view
            if (gi == 8) begin : g_bad
                assign reg_view[gi] = badvaddr_reg;
            end else if (gi == 9) begin : g_cnt
                assign reg_view[gi] = count_val;
            end else if (gi == 11) begin : g_cmp
                assign reg_view[gi] = compare_val;
            end else if (gi == 12) begin : g_sts
                assign reg_view[gi] = status_o;
            end else if (gi == 13) begin : g_cau
                assign reg_view[gi] = cause_o;
            end else if (gi == 14) begin : g_epc
                assign reg_view[gi] = epc_reg;
            end else if (gi == 15) begin : g_prid
                assign reg_view[gi] = PRID;
            end else begin : g_zero
                assign reg_view[gi] = 32'h0;
            end
        end
    endgenerate

    assign data_o = reg_view[raddr_i];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile with a rule-level reference model checked every cycle.
// Follows the DUT build: define CP0_TIMER_INT_EN for both to exercise the timer.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = 5'd0;
    logic [31:0] data_i = 32'h0;
    logic [4:0]  raddr_i = 5'd0;
    logic [5:0]  int_i = 6'h0;
    logic [31:0] except_type_i = 32'h0;
    logic [31:0] pc_i = 32'h0;
    logic        in_delayslot_i = 1'b0;
    logic [31:0] bad_addr_i = 32'h0;
    logic [31:0] data_o, status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    int tests = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    cp0_regfile dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
        .raddr_i(raddr_i), .int_i(int_i), .except_type_i(except_type_i), .pc_i(pc_i),
        .in_delayslot_i(in_delayslot_i), .bad_addr_i(bad_addr_i), .data_o(data_o),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .badvaddr_o(badvaddr_o),
        .count_o(count_o), .compare_o(compare_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    // Reference model state, one variable per architectural field.
    logic [31:0] m_status, m_epc, m_bad, m_count, m_compare;
    logic        m_bd, m_ti, m_phase;
    logic [5:0]  m_ip_hw;
    logic [1:0]  m_ip_sw;
    logic [4:0]  m_exc;

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'h0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bad;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause();
            5'd14: return m_epc;
            5'd15: return 32'h0001_8003;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit hit, cmp_wr, is_exc;
        int code;
        if (rst) begin
            m_status = 32'h0040_0000; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
            m_bd = 0; m_ti = 0; m_phase = 0; m_ip_hw = 0; m_ip_sw = 0; m_exc = 0;
        end else begin
            code   = int'(except_type_i);
            is_exc = (code == 1 || code == 4 || code == 5 || code == 8 ||
                      code == 9 || code == 10 || code == 12);
            hit    = (m_count == m_compare) && (m_compare != 0);
            cmp_wr = 0;
`ifdef CP0_TIMER_INT_EN
            if (m_phase) m_count = m_count + 1;
            m_phase = !m_phase;
`endif
            if (is_exc) begin
                if (m_status[1] == 0) begin
                    m_epc = in_delayslot_i ? pc_i - 4 : pc_i;
                    m_bd  = in_delayslot_i;
                end
                m_status[1] = 1;
                m_exc = (code == 1) ? 5'd0 : 5'(code);
                if (code == 4 || code == 5) m_bad = bad_addr_i;
            end else if (code == 14) begin
                m_status[1] = 0;
            end else if (code == 0 && we_i) begin
                if (waddr_i == 12) m_status = 32'h0040_0000 | (data_i & 32'h0000_FF03);
                if (waddr_i == 13) m_ip_sw = data_i[9:8];
                if (waddr_i == 14) m_epc = data_i;
`ifdef CP0_TIMER_INT_EN
                if (waddr_i == 9)  m_count = data_i;
                if (waddr_i == 11) begin m_compare = data_i; cmp_wr = 1; end
`endif
            end
`ifdef CP0_TIMER_INT_EN
            if (cmp_wr) m_ti = 0;
            else if (hit) m_ti = 1;
`endif
            m_ip_hw = int_i;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("status_o", status_o, m_status);
            check("cause_o", cause_o, m_cause());
            check("epc_o", epc_o, m_epc);
            check("badvaddr_o", badvaddr_o, m_bad);
            check("count_o", count_o, m_count);
            check("compare_o", compare_o, m_compare);
            check("timer_int_o", {31'h0, timer_int_o}, {31'h0, m_ti});
            check("data_o", data_o, m_read(raddr_i));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        raddr_i = raddr_i + 5'd1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1; waddr_i = a; data_i = d;
        cyc();
        we_i = 0;
        $display("[TB] mtc0 r%0d <= %h", a, d);
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                       input logic [31:0] ba);
        except_type_i = t; pc_i = pc; in_delayslot_i = ds; bad_addr_i = ba;
        cyc();
        except_type_i = 0;
        $display("[TB] exception %h pc=%h ds=%0d -> epc=%h cause=%h", t, pc, ds, epc_o, cause_o);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev_cause;
        bit found;
        rst = 1;
        cyc();
        rst = 0;
        chk_en = 1;
        repeat (10) cyc();
        $display("[TB] reset + 10 idle: status=%h count=%h cause=%h", status_o, count_o, cause_o);
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
`ifdef CP0_TIMER_INT_EN
        check("idle_count", count_o, 32'd5);
`else
        check("idle_count", count_o, 32'd0);
`endif

        mtc0(5'd11, 32'd8);
        mtc0(5'd9, 32'd6);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc();
            if (timer_int_o) found = 1;
        end
`ifdef CP0_TIMER_INT_EN
        check("timer_set", {31'h0, found}, 32'h1);
`else
        check("timer_off", {31'h0, found}, 32'h0);
`endif
        mtc0(5'd11, 32'd100);
        check("timer_clear", {31'h0, timer_int_o}, 32'h0);

        exc(32'h04, 32'hbfc0_0104, 1'b1, 32'h0000_0003);
        check("adel_epc", epc_o, 32'hbfc0_0100);
        check("adel_bd", {31'h0, cause_o[31]}, 32'h1);
        check("adel_exc", {27'h0, cause_o[6:2]}, 32'd4);
        check("adel_bad", badvaddr_o, 32'h3);
        check("adel_exl", {31'h0, status_o[1]}, 32'h1);

        exc(32'h08, 32'h0000_0080, 1'b0, 32'hdead_beef);
        check("nest_epc", epc_o, 32'hbfc0_0100);
        check("nest_exc", {27'h0, cause_o[6:2]}, 32'd8);
        check("nest_bad", badvaddr_o, 32'h3);
        exc(32'h0e, 32'h0, 1'b0, 32'h0);
        check("eret_exl", {31'h0, status_o[1]}, 32'h0);

        we_i = 1; waddr_i = 5'd14; data_i = 32'h1234;
        exc(32'h0c, 32'h0000_0040, 1'b0, 32'h0);
        we_i = 0;
        check("drop_epc", epc_o, 32'h40);
        check("drop_exc", {27'h0, cause_o[6:2]}, 32'd12);
        exc(32'h0e, 32'h0, 1'b0, 32'h0);
        exc(32'h03, 32'h0000_0999, 1'b1, 32'h0);
        check("ignored_epc", epc_o, 32'h40);

        int_i = 6'b000001;
        cyc();
        check("int_sample", {31'h0, cause_o[10]}, 32'h1);
        prev_cause = cause_o;
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_sw", cause_o ^ prev_cause, 32'h0000_0300);
        int_i = 6'b101010;
        cyc();
        check("int_pattern", {26'h0, cause_o[15:10]}, 32'h2a);

        mtc0(5'd12, 32'hFFFF_FFFF);
        check("status_mask", status_o, 32'h0040_FF03);
        mtc0(5'd12, 32'h0);
        mtc0(5'd8, 32'h5555_5555);
        mtc0(5'd15, 32'h5555_5555);
        check("bad_ro", badvaddr_o, 32'h3);
        raddr_i = 5'd14;
        #1 check("prid_read_epc", data_o, 32'h40);

        mtc0(5'd9, 32'hFFFF_FFFF);
        repeat (4) cyc();
        mtc0(5'd11, 32'd3);
        repeat (8) cyc();
        for (int a = 0; a < 32; a++) cyc();

        rst = 1;
        cyc();
        rst = 0;
        check("rst2_status", status_o, 32'h0040_0000);
        check("rst2_timer", {31'h0, timer_int_o}, 32'h0);
        check("rst2_epc", epc_o, 32'h0);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
